// File: rtl/osc_saw_meter.sv
// rtl/osc_saw_meter.sv - sawtooth period/amplitude meter with lock and stall detection
module osc_saw_meter #(
  parameter int WAVE_WIDTH_P    = 24,
  parameter int COUNTER_WIDTH_P = 24,
  parameter int TOLERANCE_P     = 2,
  parameter int LOCK_COUNT_P    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [WAVE_WIDTH_P-1:0]    osc_saw,
  input  logic                              cr_enable,
  output logic        [COUNTER_WIDTH_P-1:0] period,
  output logic                              period_valid,
  output logic signed [WAVE_WIDTH_P-1:0]    amp_max,
  output logic signed [WAVE_WIDTH_P-1:0]    amp_min,
  output logic                              locked,
  output logic                              timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SYNC    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [COUNTER_WIDTH_P-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH_P:0]   TOL     = (COUNTER_WIDTH_P+1)'(TOLERANCE_P);
  localparam logic [3:0]                 LOCK_N  = 4'(LOCK_COUNT_P);

  logic [1:0]                        state;
  logic signed [WAVE_WIDTH_P-1:0]    prev_sample;
  logic signed [WAVE_WIDTH_P-1:0]    run_max;
  logic signed [WAVE_WIDTH_P-1:0]    run_min;
  logic [COUNTER_WIDTH_P-1:0]        count;
  logic [3:0]                        match_cnt;
  logic                              have_prev;

  logic                              wrap;
  logic [COUNTER_WIDTH_P-1:0]        period_new;
  logic signed [COUNTER_WIDTH_P:0]   diff;
  logic [COUNTER_WIDTH_P:0]          abs_diff;
  logic                              is_match;
  logic [3:0]                        match_next;

  assign wrap = !prev_sample[WAVE_WIDTH_P-1] && osc_saw[WAVE_WIDTH_P-1];

  // A wrap landing on the saturated counter still publishes, clamped to the maximum.
  assign period_new = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;

  assign diff     = $signed({1'b0, period_new}) - $signed({1'b0, period});
  assign abs_diff = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
  assign is_match = have_prev && (abs_diff <= TOL);

  always_comb begin
    match_next = 4'd0;
    if (is_match) begin
      match_next = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      prev_sample  <= '0;
      run_max      <= '0;
      run_min      <= '0;
      count        <= '0;
      match_cnt    <= 4'd0;
      have_prev    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      amp_max      <= '0;
      amp_min      <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      prev_sample  <= osc_saw;
      period_valid <= 1'b0;
      if (!cr_enable) begin
        state     <= ST_IDLE;
        count     <= '0;
        match_cnt <= 4'd0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            count     <= '0;
            match_cnt <= 4'd0;
            have_prev <= 1'b0;
            state     <= ST_SYNC;
          end
          ST_SYNC: begin
            if (wrap) begin
              count     <= '0;
              run_max   <= osc_saw;
              run_min   <= osc_saw;
              have_prev <= 1'b0;
              state     <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (wrap) begin
              period       <= period_new;
              amp_max      <= run_max;
              amp_min      <= run_min;
              period_valid <= 1'b1;
              count        <= '0;
              run_max      <= osc_saw;
              run_min      <= osc_saw;
              have_prev    <= 1'b1;
              match_cnt    <= match_next;
              locked       <= (match_next == LOCK_N);
              timeout      <= 1'b0;
            end else if (count == CNT_MAX) begin
              // Stalled wave: drop lock and hunt for a fresh wrap; published values hold.
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= 4'd0;
              have_prev <= 1'b0;
              state     <= ST_SYNC;
            end else begin
              count <= count + 1'b1;
              if (osc_saw > run_max) run_max <= osc_saw;
              if (osc_saw < run_min) run_min <= osc_saw;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
